id_stage: RTL and testbench

- Instruction-decode stage. Sits between the IF/ID pipeline register and the ID/EX pipeline register, and drives every ID/EX input directly.
- Contains:
  - the 32x64 integer register file, with synchronous writeback and same-cycle write-to-read bypass;
  - main control decode and immediate generation;
  - load-use hazard detection, which stalls the front end and injects a bubble.
- Supported instructions: RV64I subset covering R-type ALU, I-type ALU, loads, stores and branches.

---
 rtl/id_stage.sv | 148 ++++++++++++++
 tb/tb_id_stage.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// Instruction-decode stage: register file, control decode,
// immediate generation and load-use hazard detection.
module id_stage #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [31:0]     IFID_Instruction,
  input  logic [XLEN-1:0] IFID_PC,
  input  logic            Flush,
  input  logic            IDEX_MemRead,
  input  logic [4:0]      IDEX_Rd,
  input  logic            WB_RegWrite,
  input  logic [4:0]      WB_Rd,
  input  logic [XLEN-1:0] WB_Data,
  output logic            RegWrite,
  output logic            MemToReg,
  output logic            Branch,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            ALUSrc,
  output logic            Shift,
  output logic [1:0]      ALUOp,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] Read_Data_1,
  output logic [XLEN-1:0] Read_Data_2,
  output logic [XLEN-1:0] Immediate,
  output logic [3:0]      Instruction_30_14_12,
  output logic [4:0]      Instruction_11_7,
  output logic            Stall
);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  logic [31:0]     instr;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [XLEN-1:0] regs [NREGS];

  assign instr  = IFID_Instruction;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (WB_RegWrite && WB_Rd != 5'd0) begin
      regs[WB_Rd] <= WB_Data;
    end
  end

  // Same-cycle writeback is forwarded so ID never reads a stale value.
  assign Read_Data_1 =
    (rs1 == 5'd0) ? '0 :
    (WB_RegWrite && WB_Rd == rs1) ? WB_Data :
    regs[rs1];

  assign Read_Data_2 =
    (rs2 == 5'd0) ? '0 :
    (WB_RegWrite && WB_Rd == rs2) ? WB_Data :
    regs[rs2];

  logic is_r;
  logic is_i;
  logic is_ld;
  logic is_st;
  logic is_br;

  assign is_r  = (opcode == OP_R);
  assign is_i  = (opcode == OP_I);
  assign is_ld = (opcode == OP_LD);
  assign is_st = (opcode == OP_ST);
  assign is_br = (opcode == OP_BR);

  // {RegWrite, MemToReg, Branch, MemRead, MemWrite, ALUSrc, ALUOp}
  logic [7:0]      ctrl;
  logic            shift_d;
  logic [XLEN-1:0] imm;

  always_comb begin
    ctrl    = '0;
    shift_d = 1'b0;
    imm     = '0;
    unique case (1'b1)
      is_r: ctrl = 8'b1000_0010;
      is_i: begin
        ctrl    = 8'b1000_0111;
        shift_d = (funct3 == 3'b001) ||
                  (funct3 == 3'b101);
        imm     = {{(XLEN-12){instr[31]}},
                   instr[31:20]};
      end
      is_ld: begin
        ctrl = 8'b1101_0100;
        imm  = {{(XLEN-12){instr[31]}},
                instr[31:20]};
      end
      is_st: begin
        ctrl = 8'b0000_1100;
        imm  = {{(XLEN-12){instr[31]}},
                instr[31:25], instr[11:7]};
      end
      is_br: begin
        ctrl = 8'b0010_0001;
        imm  = {{(XLEN-13){instr[31]}},
                instr[31], instr[7],
                instr[30:25], instr[11:8],
                1'b0};
      end
      default: ;
    endcase
  end

  logic uses_rs2;
  logic hazard;
  logic bubble;

  assign uses_rs2 = is_r || is_st || is_br;

  assign hazard =
    IDEX_MemRead && (IDEX_Rd != 5'd0) &&
    ((IDEX_Rd == rs1) ||
     ((IDEX_Rd == rs2) && uses_rs2));

  assign Stall  = reset && hazard;
  assign bubble = !reset || Stall || Flush;

  assign {RegWrite, MemToReg, Branch, MemRead,
          MemWrite, ALUSrc, ALUOp} =
    bubble ? 8'b0 : ctrl;
  assign Shift = bubble ? 1'b0 : shift_d;

  assign PC                   = IFID_PC;
  assign Immediate            = imm;
  assign Instruction_30_14_12 = {instr[30], funct3};
  assign Instruction_11_7     = instr[11:7];

endmodule

// File: tb/tb_id_stage.sv
// Directed and random checks of id_stage against
// a behavioural model of the decode stage.
module tb_id_stage;

  logic        clock;
  logic        reset;
  logic [31:0] IFID_Instruction;
  logic [63:0] IFID_PC;
  logic        Flush;
  logic        IDEX_MemRead;
  logic [4:0]  IDEX_Rd;
  logic        WB_RegWrite;
  logic [4:0]  WB_Rd;
  logic [63:0] WB_Data;
  logic        RegWrite, MemToReg, Branch, MemRead;
  logic        MemWrite, ALUSrc, Shift;
  logic [1:0]  ALUOp;
  logic [63:0] PC, Read_Data_1, Read_Data_2, Immediate;
  logic [3:0]  Instruction_30_14_12;
  logic [4:0]  Instruction_11_7;
  logic        Stall;

  id_stage dut (
    .clock(clock), .reset(reset),
    .IFID_Instruction(IFID_Instruction),
    .IFID_PC(IFID_PC), .Flush(Flush),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_Rd(IDEX_Rd),
    .WB_RegWrite(WB_RegWrite), .WB_Rd(WB_Rd),
    .WB_Data(WB_Data),
    .RegWrite(RegWrite), .MemToReg(MemToReg),
    .Branch(Branch), .MemRead(MemRead),
    .MemWrite(MemWrite), .ALUSrc(ALUSrc),
    .Shift(Shift), .ALUOp(ALUOp), .PC(PC),
    .Read_Data_1(Read_Data_1),
    .Read_Data_2(Read_Data_2),
    .Immediate(Immediate),
    .Instruction_30_14_12(Instruction_30_14_12),
    .Instruction_11_7(Instruction_11_7),
    .Stall(Stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;
  logic [63:0] m_regs [32];

  wire [8:0] ctrl_obs = {RegWrite, MemToReg, Branch,
                         MemRead, MemWrite, ALUSrc,
                         ALUOp, Shift};

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
  endtask

  function automatic logic [31:0] r_type(
    input logic [6:0] f7, input logic [4:0] s2,
    input logic [4:0] s1, input logic [2:0] f3,
    input logic [4:0] d);
    return {f7, s2, s1, f3, d, 7'h33};
  endfunction

  function automatic logic [31:0] i_type(
    input logic [11:0] im, input logic [4:0] s1,
    input logic [2:0] f3, input logic [4:0] d,
    input logic [6:0] op);
    return {im, s1, f3, d, op};
  endfunction

  function automatic logic [31:0] s_type(
    input logic [11:0] im, input logic [4:0] s2,
    input logic [4:0] s1, input logic [2:0] f3);
    return {im[11:5], s2, s1, f3, im[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] b_type(
    input logic [12:0] im, input logic [4:0] s2,
    input logic [4:0] s1, input logic [2:0] f3);
    return {im[12], im[10:5], s2, s1, f3,
            im[4:1], im[11], 7'h63};
  endfunction

  // Expected {RW,MTR,BR,MR,MW,SRC,ALUOp,Shift} for the op
  function automatic logic [8:0] m_ctrl(
    input logic [31:0] ins);
    logic [2:0] f3;
    f3 = ins[14:12];
    case (ins[6:0])
      7'h33: return 9'b1_0_0_0_0_0_10_0;
      7'h13: return {8'b1_0_0_0_0_1_11,
                     f3 == 3'd1 || f3 == 3'd5};
      7'h03: return 9'b1_1_0_1_0_1_00_0;
      7'h23: return 9'b0_0_0_0_1_1_00_0;
      7'h63: return 9'b0_0_1_0_0_0_01_0;
      default: return 9'b0;
    endcase
  endfunction

  function automatic logic [63:0] m_imm(
    input logic [31:0] ins);
    longint v;
    v = 0;
    case (ins[6:0])
      7'h13, 7'h03: begin
        v = longint'(ins[31:20]);
        if (v >= 2048) v -= 4096;
      end
      7'h23: begin
        v = longint'(ins[31:25]) * 32 +
            longint'(ins[11:7]);
        if (v >= 2048) v -= 4096;
      end
      7'h63: begin
        v = longint'(ins[31]) * 4096 +
            longint'(ins[7]) * 2048 +
            longint'(ins[30:25]) * 32 +
            longint'(ins[11:8]) * 2;
        if (v >= 4096) v -= 8192;
      end
      default: v = 0;
    endcase
    return 64'(v);
  endfunction

  function automatic logic [63:0] m_read(
    input logic [4:0] idx);
    if (idx == 0) return 64'd0;
    if (WB_RegWrite && WB_Rd == idx) return WB_Data;
    return m_regs[idx];
  endfunction

  function automatic logic m_stall();
    logic [4:0] s1, s2;
    logic [6:0] op;
    logic use2;
    s1 = IFID_Instruction[19:15];
    s2 = IFID_Instruction[24:20];
    op = IFID_Instruction[6:0];
    use2 = (op == 7'h33) || (op == 7'h23) ||
           (op == 7'h63);
    return reset && IDEX_MemRead && IDEX_Rd != 0 &&
           (IDEX_Rd == s1 || (IDEX_Rd == s2 && use2));
  endfunction

  task automatic set(input logic [31:0] ins,
                     input logic we,
                     input logic [4:0] wrd,
                     input logic [63:0] wd,
                     input logic mr,
                     input logic [4:0] ird,
                     input logic fl);
    IFID_Instruction = ins;
    IFID_PC = {$urandom, $urandom};
    WB_RegWrite = we;
    WB_Rd = wrd;
    WB_Data = wd;
    IDEX_MemRead = mr;
    IDEX_Rd = ird;
    Flush = fl;
  endtask

  // Check all outputs now, then advance past the clock edge.
  task automatic step(input string tag);
    logic st;
    logic [8:0] ec;
    #1;
    st = m_stall();
    ec = (!reset || st || Flush) ? 9'b0 :
         m_ctrl(IFID_Instruction);
    check({tag, ".ctrl"}, 64'(ctrl_obs), 64'(ec));
    check({tag, ".stall"}, 64'(Stall), 64'(st));
    check({tag, ".rd1"}, Read_Data_1,
          m_read(IFID_Instruction[19:15]));
    check({tag, ".rd2"}, Read_Data_2,
          m_read(IFID_Instruction[24:20]));
    check({tag, ".imm"}, Immediate,
          m_imm(IFID_Instruction));
    check({tag, ".pc"}, PC, IFID_PC);
    check({tag, ".f"}, 64'(Instruction_30_14_12),
          64'({IFID_Instruction[30],
               IFID_Instruction[14:12]}));
    check({tag, ".rd"}, 64'(Instruction_11_7),
          64'(IFID_Instruction[11:7]));
    if (!reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
    end else if (WB_RegWrite && WB_Rd != 0) begin
      m_regs[WB_Rd] = WB_Data;
    end
    @(negedge clock);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
    reset = 1'b0;
    set(32'h13, 0, 0, 0, 0, 0, 0);
    @(negedge clock);

    // Reset with a pending writeback and a live hazard
    set(r_type(0, 0, 5, 0, 1), 1, 5, 64'hAA, 1, 5, 0);
    #1;
    check("rst.ctrl0", 64'(ctrl_obs), 64'd0);
    check("rst.stall0", 64'(Stall), 64'd0);
    step("rst0");
    step("rst1");
    reset = 1'b1;
    set(r_type(0, 0, 5, 0, 1), 0, 0, 0, 0, 0, 0);
    #1;
    check("rst.x5", Read_Data_1, 64'd0);
    step("rst2");

    // Write x7, then read it twice
    set(32'h13, 1, 7, 64'h1234_5678_9ABC_DEF0,
        0, 0, 0);
    step("wr7");
    set(r_type(0, 7, 7, 0, 1), 0, 0, 0, 0, 0, 0);
    #1;
    check("add.rd1", Read_Data_1,
          64'h1234_5678_9ABC_DEF0);
    check("add.rd2", Read_Data_2,
          64'h1234_5678_9ABC_DEF0);
    check("add.ctrl", 64'(ctrl_obs), 64'h104);
    step("add");

    // Bypass, and x0 stays zero
    set(r_type(0, 0, 3, 0, 1), 1, 3, 64'h55, 0, 0, 0);
    #1;
    check("byp.x3", Read_Data_1, 64'h55);
    step("byp");
    set(i_type(0, 0, 0, 1, 7'h13), 1, 0, 64'hFF,
        0, 0, 0);
    #1;
    check("x0.same", Read_Data_1, 64'd0);
    step("x0w");
    set(i_type(0, 0, 0, 1, 7'h13), 0, 0, 0, 0, 0, 0);
    #1;
    check("x0.read", Read_Data_1, 64'd0);
    step("x0r");

    // Immediates
    set(i_type(12'hFFC, 2, 3'b010, 5, 7'h03),
        0, 0, 0, 0, 0, 0);
    #1;
    check("lw.imm", Immediate, 64'hFFFF_FFFF_FFFF_FFFC);
    check("lw.ctrl", 64'(ctrl_obs), 64'h1A8);
    step("lw");
    set(s_type(12'hFF8, 3, 2, 3'b010),
        0, 0, 0, 0, 0, 0);
    #1;
    check("sw.imm", Immediate, 64'hFFFF_FFFF_FFFF_FFF8);
    step("sw");
    set(b_type(13'h1FFC, 2, 1, 3'b000),
        0, 0, 0, 0, 0, 0);
    #1;
    check("beq.imm", Immediate,
          64'hFFFF_FFFF_FFFF_FFFC);
    check("beq.ctrl", 64'(ctrl_obs), 64'h042);
    step("beq");

    // Load-use
    set(r_type(0, 4, 2, 0, 6), 0, 0, 0, 1, 4, 0);
    #1;
    check("lu.stall", 64'(Stall), 64'd1);
    check("lu.ctrl", 64'(ctrl_obs), 64'd0);
    step("lu");
    set(i_type(12'd4, 2, 0, 6, 7'h13), 0, 0, 0, 1, 4, 0);
    #1;
    check("lu.addi", 64'(Stall), 64'd0);
    step("lu_addi");
    set(r_type(0, 0, 0, 0, 6), 0, 0, 0, 1, 0, 0);
    #1;
    check("lu.rd0", 64'(Stall), 64'd0);
    step("lu_rd0");

    // Flush and shift
    set(i_type(12'd3, 1, 3'b001, 1, 7'h13),
        0, 0, 0, 0, 0, 1);
    #1;
    check("fl.ctrl", 64'(ctrl_obs), 64'd0);
    check("fl.stall", 64'(Stall), 64'd0);
    step("flush");
    set(i_type(12'd3, 1, 3'b001, 1, 7'h13),
        0, 0, 0, 0, 0, 0);
    #1;
    check("slli.ctrl", 64'(ctrl_obs), 64'h10F);
    check("slli.f", 64'(Instruction_30_14_12), 64'h1);
    step("slli");

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins;
      logic [6:0] ops [6];
      logic [4:0] ird;
      ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37};
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 5)];
      case ($urandom_range(0, 3))
        0: ird = ins[19:15];
        1: ird = ins[24:20];
        default: ird = 5'($urandom);
      endcase
      reset = ($urandom_range(0, 49) != 0);
      set(ins, 1'($urandom),
          ($urandom_range(0, 2) == 0) ?
            ins[19:15] : 5'($urandom),
          {$urandom, $urandom},
          1'($urandom), ird,
          ($urandom_range(0, 7) == 0));
      step("rnd");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
